// File: rtl/rf_dump_ctrl.sv
// rtl/rf_dump_ctrl.sv - sweeps a register file and streams every entry out as indexed beats
// The read address is the live index counter; the output stage is a single registered beat slot.
module rf_dump_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic capture;
  logic handshake;

  // The slot refills whenever it is empty or being emptied this cycle.
  assign capture   = (state_q == S_SCAN) && (!valid_q || out_ready);
  assign handshake = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_SCAN;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_SCAN, S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (capture) begin
          data_d  = rf_rdata;
          idx_d   = cnt_q;
          valid_d = 1'b1;
          last_d  = (cnt_q == LAST_IDX);
          if (cnt_q == LAST_IDX) begin
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (handshake) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = S_IDLE;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rf_raddr  = cnt_q;
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// tb/tb_rf_dump_ctrl.sv - scoreboard bench for rf_dump_ctrl
// Stimulus pushes expected beats; a negedge monitor pops them on every accepted beat.
module tb_rf_dump_ctrl;

  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] rf_mem [0:NR-1];

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  rf_dump_ctrl #(.NUM_REGS(NR), .ADDR_W(5), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  assign rf_rdata = rf_mem[rf_raddr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int p, input int i);
    if (p == 0) return 32'(i + 1);
    return 32'hA500_0000 + 32'(i * 3);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks hold-stability under backpressure.
  logic        hold_v = 1'b0;
  logic [4:0]  hold_idx;
  logic [31:0] hold_data;
  logic        hold_last;

  always @(negedge clk) begin
    if (!rst) begin
      if (hold_v) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_idx", out_idx, hold_idx);
        chk("hold_data", out_data, hold_data);
        chk("hold_last", out_last, hold_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got idx %0d expected none", out_idx);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_idx", out_idx, e.idx);
          chk("beat_data", out_data, e.data);
          chk("beat_last", out_last, e.last);
        end
      end
      if (done) done_cnt++;
      hold_v    = out_valid && !out_ready;
      hold_idx  = out_idx;
      hold_data = out_data;
      hold_last = out_last;
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int p);
    for (int i = 0; i < NR; i++) rf_mem[i] = pat(p, i);
  endtask

  task automatic push_dump(input int p);
    for (int i = 0; i < NR; i++) begin
      beat_t b;
      b.idx  = 5'(i);
      b.data = pat(p, i);
      b.last = (i == NR - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_start(output int n);
    start = 1'b1;
    n = cyc;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready high, 1: ready toggling, 2: ready low for 10 cycles from first beat
  task automatic run_dump(input int mode, input int n, input int p);
    int fv;
    int dc;
    fv = -1;
    dc = -1;
    for (int k = 0; k < 400; k++) begin
      if (out_valid && fv < 0) fv = cyc;
      if (mode == 1) out_ready = ~out_ready;
      else if (mode == 2 && fv >= 0 && cyc < fv + 10) begin
        out_ready = 1'b0;
        chk("stall_idx", out_idx, 5'd0);
        chk("stall_data", out_data, pat(p, 0));
        chk("stall_raddr", rf_raddr, 5'd1);
      end else out_ready = 1'b1;
      if (done) begin
        dc = cyc;
        break;
      end
      tick();
    end
    out_ready = 1'b1;
    if (dc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got none expected done pulse");
    end
    if (n >= 0) chk("first_beat_cycle", 64'(fv), 64'(n + 2));
    if (n >= 0 && mode == 0) chk("done_cycle", 64'(dc), 64'(n + 34));
  endtask

  task automatic wait_idx(input int idx);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (out_valid && out_idx == 5'(idx)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("reach_idx", 64'(ok), 64'd1);
  endtask

  initial begin
    int n;
    int d;
    load(0);
    repeat (3) tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_idx", out_idx, 5'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_raddr", rf_raddr, 5'd0);
    rst = 1'b0;
    tick();

    d = done_cnt;
    push_dump(0);
    pulse_start(n);
    chk("busy_after_start", busy, 1'b1);
    run_dump(0, n, 0);

    // start coincides with done: a new dump begins immediately
    push_dump(0);
    pulse_start(n);
    run_dump(1, n, 0);
    repeat (2) tick();
    chk("done_count_t2", 64'(done_cnt), 64'(d + 2));

    push_dump(0);
    pulse_start(n);
    run_dump(2, n, 0);
    repeat (2) tick();

    d = done_cnt;
    push_dump(0);
    pulse_start(n);
    wait_idx(7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_last", out_last, 1'b0);
    chk("abort_raddr", rf_raddr, 5'd0);
    chk("abort_left", 64'(exp_q.size()), 64'd24);
    exp_q.delete();
    repeat (5) tick();
    chk("abort_no_done", 64'(done_cnt), 64'(d));
    push_dump(0);
    pulse_start(n);
    run_dump(0, n, 0);
    repeat (2) tick();

    d = done_cnt;
    push_dump(0);
    pulse_start(n);
    wait_idx(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_dump(0, -1, 0);
    repeat (5) tick();
    chk("restart_ignored_valid", out_valid, 1'b0);
    chk("restart_ignored_done", 64'(done_cnt), 64'(d + 1));

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins_busy", busy, 1'b0);
    repeat (2) tick();
    chk("abort_wins_valid", out_valid, 1'b0);

    d = done_cnt;
    load(1);
    push_dump(1);
    pulse_start(n);
    wait_idx(15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_idx", out_idx, 5'd0);
    chk("midrst_data", out_data, 32'd0);
    chk("midrst_last", out_last, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_raddr", rf_raddr, 5'd0);
    chk("midrst_left", 64'(exp_q.size()), 64'd17);
    exp_q.delete();
    repeat (5) tick();
    chk("midrst_no_done", 64'(done_cnt), 64'(d));
    push_dump(1);
    pulse_start(n);
    run_dump(0, n, 1);
    repeat (3) tick();
    chk("midrst_done", 64'(done_cnt), 64'(d + 1));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
